// File: rtl/load_sequencer.sv
// Turns per-period duty commands into an A/B/C DesiredLoad sequence and a
// debounced current sign for the matrix-converter commutation FSM.
module load_sequencer #(
  parameter int CW      = 12,
  parameter int DEB     = 4,
  parameter int MIN_SEG = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] duty_a,
  input  logic [CW-1:0] duty_b,
  input  logic          duty_load,
  input  logic          i_sense,
  output logic [1:0]    DesiredLoad,
  output logic          CurrentSign,
  output logic          start,
  output logic          period_tick,
  output logic          duty_err
);

  typedef enum logic [1:0] {IDLE = 2'b00, SEG_A = 2'b01, SEG_B = 2'b10, SEG_C = 2'b11} state_t;

  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;

  state_t        r_state, w_nstate, w_fst;
  logic [CW-1:0] r_cnt, w_ncnt, w_flen;
  logic [CW-1:0] r_pp, r_pa, r_pb, r_pc;
  // A's length is only needed when a period starts, and that always comes from pending.
  logic [CW-1:0] r_ab, r_ac;
  logic          r_new, w_new, w_copy, w_bound;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_dc;
  logic          w_rej;
  logic          r_s1, r_s2;
  logic [DW-1:0] r_dcnt;

  function automatic logic f_short(input logic [CW-1:0] x);
    return (x != '0) && (x < CW'(MIN_SEG));
  endfunction

  assign w_sum = {1'b0, duty_a} + {1'b0, duty_b};
  assign w_dc  = period - duty_a - duty_b;
  assign w_rej = (w_sum > {1'b0, period}) || (period == '0) ||
                 f_short(duty_a) || f_short(duty_b) || f_short(w_dc);

  assign w_fst  = (r_pa != '0) ? SEG_A : (r_pb != '0) ? SEG_B : SEG_C;
  assign w_flen = (r_pa != '0) ? r_pa  : (r_pb != '0) ? r_pb  : r_pc;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_copy   = 1'b0;
    w_new    = 1'b0;
    w_bound  = 1'b0;
    if (!enable) begin
      w_nstate = IDLE;
      w_ncnt   = '0;
    end else if (r_state == IDLE) begin
      w_bound = 1'b1;
    end else if (r_cnt != '0) begin
      w_ncnt = r_cnt - CW'(1);
    end else if (r_state == SEG_A && r_ab != '0) begin
      w_nstate = SEG_B;
      w_ncnt   = r_ab - CW'(1);
    end else if (r_state != SEG_C && r_ac != '0) begin
      w_nstate = SEG_C;
      w_ncnt   = r_ac - CW'(1);
    end else begin
      w_bound = 1'b1;
    end
    // Period boundary: latch pending and jump straight to its first non-zero segment.
    if (w_bound) begin
      if (r_pp != '0) begin
        w_copy   = 1'b1;
        w_new    = 1'b1;
        w_nstate = w_fst;
        w_ncnt   = w_flen - CW'(1);
      end else begin
        w_nstate = IDLE;
        w_ncnt   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_new       <= 1'b0;
      r_pp        <= '0;
      r_pa        <= '0;
      r_pb        <= '0;
      r_pc        <= '0;
      r_ab        <= '0;
      r_ac        <= '0;
      DesiredLoad <= 2'b00;
      start       <= 1'b0;
      period_tick <= 1'b0;
      duty_err    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_new   <= w_new;
      if (w_copy) begin
        r_ab <= r_pb;
        r_ac <= r_pc;
      end
      if (duty_load && !w_rej) begin
        r_pp <= period;
        r_pa <= duty_a;
        r_pb <= duty_b;
        r_pc <= w_dc;
      end
      duty_err    <= duty_load && w_rej;
      // Outputs trail the state by one cycle, but drop with enable at once.
      DesiredLoad <= enable ? 2'(r_state) : 2'b00;
      start       <= enable && (r_state != IDLE);
      period_tick <= enable && r_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_dcnt      <= '0;
      CurrentSign <= 1'b0;
    end else begin
      r_s1 <= i_sense;
      r_s2 <= r_s1;
      if (r_s2 != CurrentSign) begin
        if (r_dcnt == DW'(DEB - 1)) begin
          CurrentSign <= ~CurrentSign;
          r_dcnt      <= '0;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end else begin
        r_dcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Random and directed stimulus for load_sequencer against a period-position
// reference model.
module tb_load_sequencer;
  localparam int CW = 12, DEB = 4, MIN_SEG = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          enable = 1'b0, duty_load = 1'b0, i_sense = 1'b0;
  logic [CW-1:0] period = '0, duty_a = '0, duty_b = '0;
  logic [1:0]    DesiredLoad;
  logic          CurrentSign, start, period_tick, duty_err;

  load_sequencer #(.CW(CW), .DEB(DEB), .MIN_SEG(MIN_SEG)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .duty_a(duty_a),
    .duty_b(duty_b), .duty_load(duty_load), .i_sense(i_sense),
    .DesiredLoad(DesiredLoad), .CurrentSign(CurrentSign), .start(start),
    .period_tick(period_tick), .duty_err(duty_err)
  );

  always #5 clk = ~clk;

  int vec = 0, miscmp = 0;
  // reference model: pending/active sets, position within period, debounce
  int mp, ma, mb, ap, aa, ab, t;
  bit run;
  int h1, h2, cs, drun;
  int e_dl, e_st, e_tk, e_er;
  logic g_en = 1'b0, g_s = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    vec++;
    if (obs != exp) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mreset();
    mp = 0; ma = 0; mb = 0; ap = 0; aa = 0; ab = 0; t = 0; run = 0;
    h1 = 0; h2 = 0; cs = 0; drun = 0;
    e_dl = 0; e_st = 0; e_tk = 0; e_er = 0;
  endtask

  function automatic bit is_short(input int x);
    return x > 0 && x < MIN_SEG;
  endfunction

  function automatic int code_at(input int pos);
    if (pos < aa) return 1;
    if (pos < aa + ab) return 2;
    return 3;
  endfunction

  task automatic mstep(input bit en, input bit ld, input int p, input int a, input int b, input bit s);
    int dc;
    bit rej, cur_new;
    int cur_code;
    cur_code = run ? code_at(t) : 0;
    cur_new  = run && (t == 0);
    e_dl = en ? cur_code : 0;
    e_st = en && run;
    e_tk = en && cur_new;
    if (!en) run = 0;
    else if (!run) begin
      if (mp != 0) begin run = 1; t = 0; ap = mp; aa = ma; ab = mb; end
    end else begin
      t++;
      if (t == ap) begin t = 0; ap = mp; aa = ma; ab = mb; end
    end
    dc  = p - a - b;
    rej = (p == 0) || (dc < 0) || is_short(a) || is_short(b) || is_short(dc);
    e_er = ld && rej;
    if (ld && !rej) begin mp = p; ma = a; mb = b; end
    if (h2 != cs) begin
      drun++;
      if (drun == DEB) begin cs = 1 - cs; drun = 0; end
    end else drun = 0;
    h2 = h1; h1 = s;
  endtask

  task automatic cyc(input bit ld = 0, input int p = 0, input int a = 0, input int b = 0);
    @(negedge clk);
    enable = g_en; i_sense = g_s; duty_load = ld;
    period = CW'(p); duty_a = CW'(a); duty_b = CW'(b);
    @(posedge clk);
    mstep(g_en, ld, p, a, b, g_s);
    #1;
    chk("DesiredLoad", DesiredLoad, e_dl);
    chk("start", start, e_st);
    chk("period_tick", period_tick, e_tk);
    chk("duty_err", duty_err, e_er);
    chk("CurrentSign", CurrentSign, cs);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dl"}, DesiredLoad, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_tick"}, period_tick, 0);
    chk({tag, "_err"}, duty_err, 0);
    chk({tag, "_cs"}, CurrentSign, 0);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    bit hit;
    mreset();
    #1 chk_all_zero("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    g_en = 1'b1;
    run_n(6);                            // no load yet: stays idle
    cyc(1, 20, 8, 5);
    run_n(45);
    cyc(1, 20, 15, 10);                  // overflow reject
    run_n(10);
    cyc(1, 20, 2, 8);                    // short segment reject
    run_n(10);
    cyc(1, 0, 0, 0);                     // zero period reject
    run_n(5);
    cyc(1, 20, 8, 0);                    // B skipped
    run_n(45);
    cyc(1, 20, 8, 5);
    run_n(22);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (period_tick) hit = 1; else cyc();
    end
    chk("wait_tick", hit, 1);
    run_n(4);
    cyc(1, 12, 4, 4);                    // mid-period update
    run_n(40);

    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (DesiredLoad == 2'b10) hit = 1; else cyc();
    end
    chk("wait_segB", hit, 1);
    g_en = 1'b0; cyc();                  // drop mid-SEG_B
    chk("drop_dl", DesiredLoad, 0);
    g_en = 1'b1; run_n(30);

    g_s = 1'b1; run_n(3); g_s = 1'b0;    // glitch
    run_n(10);
    chk("glitch_cs", CurrentSign, 0);
    g_s = 1'b1; run_n(12);
    chk("held_cs", CurrentSign, 1);
    g_s = 1'b0; run_n(10);

    @(negedge clk); #1 rst = 1'b0;       // asynchronous reset mid-run
    #1 chk_all_zero("rst_mid");
    mreset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    run_n(8);

    for (int i = 0; i < 4000; i++) begin
      int p, a, b;
      g_en = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) g_s = ~g_s;
      if ($urandom_range(0, 19) == 0) begin
        p = $urandom_range(0, 40);
        a = $urandom_range(0, p + 2);
        b = $urandom_range(0, p + 2);
        cyc(1, p, a, b);
      end else cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
